// File: rtl/adc_tick_scheduler.sv
// Staggered ADC frame-tick scheduler: NUM_TAPS programmable delayed ticks, frame/overrun counters, watchdog.
// Optional ADC_TICK_SCHEDULER_TIMESTAMP_EN adds timestamp_o latched from a free-running cycle counter.
module adc_tick_scheduler #(
  parameter int NUM_TAPS = 4,
  parameter int CNT_W    = 10,
  parameter int FRAME_W  = 32,
  parameter int TIMEOUT  = 2048,
  parameter int RESTART  = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      tick_i,
  input  logic [NUM_TAPS*CNT_W-1:0] delay_i,
  output logic [NUM_TAPS-1:0]       tap_o,
  output logic                      active_o,
  output logic [FRAME_W-1:0]        frame_cnt_o,
  output logic                      overrun_o,
  output logic [15:0]               overrun_cnt_o,
  output logic                      timeout_o
`ifdef ADC_TICK_SCHEDULER_TIMESTAMP_EN
  ,
  output logic [31:0]               timestamp_o
`endif
);

  // state  | meaning
  // S_IDLE | no frame schedule pending
  // S_RUN  | phase counts cycles since the accepted tick; taps compare against shadow delays
  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

  state_t           state, state_next;
  logic [CNT_W-1:0] shadow [NUM_TAPS];
  logic [CNT_W-1:0] dmax, dmax_in, phase;
  logic [15:0]      idle_cnt;
  logic             last, accept, overrun_det;

  always_comb begin
    dmax_in = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (delay_i[k*CNT_W +: CNT_W] > dmax_in) dmax_in = delay_i[k*CNT_W +: CNT_W];
    end
  end

  // A tick in the last tap cycle starts a new frame cleanly and is never an overrun.
  always_comb begin
    last        = (state == S_RUN) && (phase == dmax);
    overrun_det = tick_i && (state == S_RUN) && !last;
    accept      = tick_i && ((state == S_IDLE) || last || (RESTART != 0));
    state_next  = state;
    if (accept)    state_next = (dmax_in != '0) ? S_RUN : S_IDLE;
    else if (last) state_next = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= S_IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      phase <= '0;
      dmax  <= '0;
      for (int k = 0; k < NUM_TAPS; k++) shadow[k] <= '0;
    end else if (accept) begin
      phase <= CNT_W'(1);
      dmax  <= dmax_in;
      for (int k = 0; k < NUM_TAPS; k++) shadow[k] <= delay_i[k*CNT_W +: CNT_W];
    end else if ((state == S_RUN) && !last) begin
      phase <= phase + CNT_W'(1);
    end
  end

  always_comb begin
    tap_o = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      tap_o[k] = (state == S_RUN) && (shadow[k] != '0) && (phase == shadow[k]);
    end
  end

  assign active_o = (state == S_RUN);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      frame_cnt_o   <= '0;
      overrun_o     <= 1'b0;
      overrun_cnt_o <= '0;
    end else begin
      overrun_o <= overrun_det;
      if (accept) frame_cnt_o <= frame_cnt_o + FRAME_W'(1);
      if (overrun_det && (overrun_cnt_o != 16'hFFFF)) overrun_cnt_o <= overrun_cnt_o + 16'd1;
    end
  end

  // Watchdog: any tick, accepted or dropped, proves the ADC is alive.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)                   idle_cnt <= '0;
    else if (tick_i)                 idle_cnt <= '0;
    else if (idle_cnt != TIMEOUT_L)  idle_cnt <= idle_cnt + 16'd1;
  end

  assign timeout_o = (idle_cnt == TIMEOUT_L);

`ifdef ADC_TICK_SCHEDULER_TIMESTAMP_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cycle_cnt   <= '0;
      timestamp_o <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (accept) timestamp_o <= cycle_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_adc_tick_scheduler.sv
// Directed bench for adc_tick_scheduler: table-driven single frames plus restart, back-to-back,
// watchdog and mid-frame reset sequences; timestamp check when ADC_TICK_SCHEDULER_TIMESTAMP_EN is defined.
module tb_adc_tick_scheduler;
  localparam int NT = 4;
  localparam int CW = 10;
  localparam int FW = 32;
  localparam logic [NT*CW-1:0] ALL7 = {4{10'd7}};
  localparam logic [NT*CW-1:0] D50  = {10'd0, 10'd0, 10'd0, 10'd50};
  localparam logic [NT*CW-1:0] D40  = {10'd0, 10'd0, 10'd0, 10'd40};

  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic [NT*CW-1:0] delay = '0;
  logic [NT-1:0] tap, tap_nr;
  logic active, active_nr, ovr, ovr_nr, to, to_nr;
  logic [FW-1:0] fc, fc_nr;
  logic [15:0] oc, oc_nr;
`ifdef ADC_TICK_SCHEDULER_TIMESTAMP_EN
  logic [31:0] ts, ts_nr;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_tick_scheduler #(.NUM_TAPS(NT), .CNT_W(CW), .FRAME_W(FW), .TIMEOUT(64), .RESTART(1)) dut (
    .clk_i(clk), .reset_ni(rst_n), .tick_i(tick), .delay_i(delay), .tap_o(tap),
    .active_o(active), .frame_cnt_o(fc), .overrun_o(ovr), .overrun_cnt_o(oc), .timeout_o(to)
`ifdef ADC_TICK_SCHEDULER_TIMESTAMP_EN
    , .timestamp_o(ts)
`endif
  );

  adc_tick_scheduler #(.NUM_TAPS(NT), .CNT_W(CW), .FRAME_W(FW), .TIMEOUT(64), .RESTART(0)) dut_nr (
    .clk_i(clk), .reset_ni(rst_n), .tick_i(tick), .delay_i(delay), .tap_o(tap_nr),
    .active_o(active_nr), .frame_cnt_o(fc_nr), .overrun_o(ovr_nr), .overrun_cnt_o(oc_nr), .timeout_o(to_nr)
`ifdef ADC_TICK_SCHEDULER_TIMESTAMP_EN
    , .timestamp_o(ts_nr)
`endif
  );

  typedef struct {
    logic [NT*CW-1:0] delays;
    int               dmax;
    int               fires;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    tick  = 1'b0;
    #1;
    chk("rst_tap", tap, 0);
    chk("rst_active", active, 0);
    chk("rst_frame_cnt", fc, 0);
    chk("rst_overrun", ovr, 0);
    chk("rst_overrun_cnt", oc, 0);
    chk("rst_timeout", to, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [NT-1:0] exp_tap;
    int fires, last_act, dk;

    vecs[0] = '{{10'd0,   10'd0,  10'd0,  10'd100}, 100,  1};
    vecs[1] = '{{10'd1023,10'd20, 10'd20, 10'd5},   1023, 3};
    vecs[2] = '{{10'd0,   10'd0,  10'd0,  10'd0},   0,    0};
    vecs[3] = '{{10'd1,   10'd1,  10'd1,  10'd1},   1,    1};
    vecs[4] = '{{10'd2,   10'd7,  10'd0,  10'd3},   7,    3};

    do_reset();

    // single frames; delay_i is changed to all-7 from cycle 3 and must be ignored
    for (int v = 0; v < 5; v++) begin
      repeat (3) next_cycle();
      fires = 0;
      last_act = -1;
      for (int j = 0; j <= vecs[v].dmax + 2; j++) begin
        next_cycle();
        tick  = (j == 0);
        delay = (j >= 3) ? ALL7 : vecs[v].delays;
        @(negedge clk);
        for (int k = 0; k < NT; k++) begin
          dk = int'(vecs[v].delays[k*CW +: CW]);
          exp_tap[k] = (dk != 0) && (j == dk);
        end
        chk($sformatf("v%0d_tap_c%0d", v, j), tap, exp_tap);
        chk($sformatf("v%0d_active_c%0d", v, j), active, (j >= 1) && (j <= vecs[v].dmax));
        if (j == 0) chk($sformatf("v%0d_fc_before", v), fc, v);
        if (j == 1) chk($sformatf("v%0d_fc_after", v), fc, v + 1);
        if (|tap) fires++;
        if (active) last_act = j;
      end
      tick = 1'b0;
      chk($sformatf("v%0d_fire_cycles", v), fires, vecs[v].fires);
      chk($sformatf("v%0d_last_active", v), last_act, (vecs[v].dmax == 0) ? -1 : vecs[v].dmax);
      chk($sformatf("v%0d_no_overrun", v), oc, 0);
    end

    // retrigger mid-frame: RESTART=1 reschedules, RESTART=0 drops the tick
    do_reset();
    for (int j = 0; j <= 85; j++) begin
      next_cycle();
      tick  = (j == 0) || (j == 30);
      delay = D50;
      @(negedge clk);
      chk($sformatf("rs_tap_c%0d", j), tap, (j == 80) ? 4'b0001 : 4'b0000);
      chk($sformatf("nr_tap_c%0d", j), tap_nr, (j == 50) ? 4'b0001 : 4'b0000);
      chk($sformatf("rs_ovr_c%0d", j), ovr, j == 31);
      chk($sformatf("nr_ovr_c%0d", j), ovr_nr, j == 31);
    end
    tick = 1'b0;
    chk("rs_frame_cnt", fc, 2);
    chk("nr_frame_cnt", fc_nr, 1);
    chk("rs_overrun_cnt", oc, 1);
    chk("nr_overrun_cnt", oc_nr, 1);

    // tick exactly on the last tap cycle starts the next frame without overrun
    do_reset();
    for (int j = 0; j <= 85; j++) begin
      next_cycle();
      tick  = (j == 0) || (j == 40);
      delay = D40;
      @(negedge clk);
      chk($sformatf("b2b_tap_c%0d", j), tap, ((j == 40) || (j == 80)) ? 4'b0001 : 4'b0000);
      chk($sformatf("b2b_nr_tap_c%0d", j), tap_nr, ((j == 40) || (j == 80)) ? 4'b0001 : 4'b0000);
      chk($sformatf("b2b_active_c%0d", j), active, (j >= 1) && (j <= 80));
      chk($sformatf("b2b_ovr_c%0d", j), ovr | ovr_nr, 0);
    end
    tick = 1'b0;
    chk("b2b_frame_cnt", fc, 2);
    chk("b2b_nr_frame_cnt", fc_nr, 2);
    chk("b2b_overrun_cnt", oc, 0);

    // watchdog with TIMEOUT=64
    do_reset();
    for (int c = 1; c <= 104; c++) begin
      next_cycle();
      tick = (c == 100);
      delay = '0;
      @(negedge clk);
      chk($sformatf("to_c%0d", c), to, (c >= 64) && (c <= 100));
    end
    tick = 1'b0;

    // reset in the middle of a 50-cycle frame
    do_reset();
    for (int j = 0; j <= 20; j++) begin
      next_cycle();
      tick  = (j == 0);
      delay = D50;
      @(negedge clk);
    end
    tick = 1'b0;
    chk("mid_active_before", active, 1);
    chk("mid_fc_before", fc, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_active_async", active, 0);
    chk("mid_fc_async", fc, 0);
    chk("mid_tap_async", tap, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("mid_tap_c%0d", c), tap, 0);
      chk($sformatf("mid_active_c%0d", c), active, 0);
    end

`ifdef ADC_TICK_SCHEDULER_TIMESTAMP_EN
    begin
      logic [31:0] ts_a, ts_b;
      do_reset();
      for (int j = 0; j <= 1001; j++) begin
        next_cycle();
        tick  = (j == 0) || (j == 1000);
        delay = {10'd0, 10'd0, 10'd0, 10'd5};
        @(negedge clk);
        if (j == 1)    ts_a = ts;
        if (j == 1001) ts_b = ts;
      end
      tick = 1'b0;
      chk("ts_delta", ts_b - ts_a, 1000);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_tick_scheduler.md
Name: adc_tick_scheduler

Overview:
Parametrised successor of the fixed 100-cycle master-tick delay used behind the ADC readers. It takes the raw ADC frame tick and emits NUM_TAPS one-cycle ticks, each at its own programmable delay. This lets the QPD, OPD and reference filter chains start at staggered, jitter-free offsets. It also adds what the fixed delay lacked: frame counting, overrun detection on early retrigger, and a missing-frame watchdog.

Parameters:
NUM_TAPS, 4, number of delayed tick outputs (1..8)
CNT_W, 10, width of each tap delay value and of the internal phase counter
FRAME_W, 32, width of the frame counter
TIMEOUT, 2048, idle cycles without tick_i before timeout_o asserts (must be < 2^16)
RESTART, 1, 1 = tick_i during an active frame restarts the schedule; 0 = that tick is ignored

Ports:
clk_i  in  1  system clock
reset_ni  in  1  asynchronous active-low reset
tick_i  in  1  one-cycle ADC frame-ready pulse (e.g. DoutReader tick_o)
delay_i  in  NUM_TAPS*CNT_W  tap k delay in bits [k*CNT_W +: CNT_W]; 0 = tap disabled
tap_o  out  NUM_TAPS  one-cycle delayed ticks
active_o  out  1  frame schedule in progress
frame_cnt_o  out  FRAME_W  accepted frame count
overrun_o  out  1  one-cycle pulse on tick_i during an active frame
overrun_cnt_o  out  16  saturating overrun count
timeout_o  out  1  level; ADC frames stalled

Behaviour:
- Interface: one clock, clk_i. Reset reset_ni is asynchronous and active-low. All state clears immediately on reset_ni=0, and flops run on the first rising edge after deassertion.
- Reset values: tap_o=0, active_o=0, frame_cnt_o=0, overrun_o=0, overrun_cnt_o=0, timeout_o=0. Internal phase=0, idle count=0.
- Accepted tick: tick_i=1 while active_o=0, or while active_o=1 with RESTART=1.
  - On an accepted tick at cycle t, delay_i is captured into shadow registers.
  - Later delay_i changes do not affect the running frame.
- Taps: for captured D_k != 0, tap_o[k]=1 exactly in cycle t+D_k, for one cycle, and 0 otherwise. Equal delays fire together.
- Dmax is the maximum captured D_k.
  - active_o=1 from cycle t+1 through cycle t+Dmax inclusive, then 0.
  - If all D_k=0: no taps fire, active_o stays 0, and the frame is still counted.
- frame_cnt_o increments at t+1 for every accepted tick and wraps modulo 2^FRAME_W.
- Overrun: tick_i=1 while active_o=1 and not in cycle t+Dmax.
  - overrun_o pulses in the next cycle.
  - overrun_cnt_o increments, saturating at 16'hFFFF.
  - RESTART=1: taps due in the retrigger cycle itself still fire. The rest of the old schedule is discarded and the new schedule runs from the retrigger cycle.
  - RESTART=0: the tick is dropped, the schedule is unchanged, and frame_cnt_o is not incremented.
- tick_i in cycle t+Dmax (the last tap cycle): this is not an overrun. It is accepted, the final tap still fires, and the new frame starts.
- Watchdog: the idle counter clears on any tick_i (accepted or not), otherwise increments, saturating at TIMEOUT.
  - timeout_o=1 while idle count == TIMEOUT.
  - timeout_o drops in the cycle after the next tick_i.
- Reset mid-frame: the pending schedule is lost, and no tap fires after reset release until a new tick_i.
- The phase counter is CNT_W wide and never wraps, because the frame ends at Dmax ≤ 2^CNT_W−1.

Optional Feature:
ADC_TICK_SCHEDULER_TIMESTAMP_EN: when defined, adds output timestamp_o [31:0] and a free-running 32-bit cycle counter.
- The counter resets to 0 and wraps.
- On every accepted tick_i, the counter value in that cycle is latched to timestamp_o, visible from t+1. Reset value is 0.
- When undefined, the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Delays {100,0,0,0}, single tick_i at cycle 10 → tap_o[0] high only at cycle 110; active_o high 11..110; frame_cnt_o=1 from cycle 11.
- Delays {5,20,20,1023}, tick at 0, delay_i changed to all 7 at cycle 3 → taps at 5, 20, 20 (taps 1 and 2 together), 1023; the change is ignored.
- RESTART=1, delays {50,...}, ticks at 0 and 30 → overrun_o at 31, overrun_cnt_o=1, tap_o[0] only at 80, frame_cnt_o=2. RESTART=0, same stimulus → tap at 50 only, frame_cnt_o=1.
- Delays {40,...}, ticks at 0 and 40 → taps at 40 and 80, no overrun_o, frame_cnt_o=2.
- TIMEOUT=64, no tick for 100 cycles after reset → timeout_o rises at cycle 64 after release; tick at 100 → timeout_o low from 101.
- reset_ni pulsed low at cycle 20 of a 50-delay frame → outputs 0 asynchronously and no tap at 50. With the timestamp macro defined, ticks 1000 cycles apart give timestamp_o differences of exactly 1000.
